xdma_pckt_chk: RTL
==================

Name: xdma_pckt_chk

Overview:
- Host-to-card (H2C) stream sink and checker. It sits on the XDMA H2C AXI-Stream master, in the user_clk domain.
- Checks every accepted beat against the counter pattern that the card-to-host (C2H) packet generator produces: 64-bit word {cnt[30:0], 1'b1, cnt[30:0], 1'b0}, cnt incrementing by one per beat, tlast on the beat where cnt[8:0]==9'h1FF (512-beat / 4 kB packets).
- Exposes lock state, beat, packet and error counters, and a first-error capture for register readback.

Parameters:
- C_DATA_WIDTH, 64, stream data width; only 64 is implemented.
- KEEP_WIDTH, C_DATA_WIDTH/8, tkeep width; do not override.
- PKT_LOG2, 9, log2 of beats per packet; tlast is expected when cnt[PKT_LOG2-1:0] is all ones.
- ERR_W, 16, width of the error counters.
- TCQ, 1, simulation clock-to-q delay on all register assignments.

Ports:
- user_clk, in, 1, the only clock (XDMA user clock).
- user_resetn, in, 1, asynchronous active-low reset.
- s_axis_tvalid, in, 1, H2C beat valid.
- s_axis_tready, out, 1, H2C ready.
- s_axis_tdata, in, C_DATA_WIDTH, H2C data.
- s_axis_tkeep, in, KEEP_WIDTH, H2C byte keep.
- s_axis_tlast, in, 1, H2C end of packet.
- enable, in, 1, level; the checker accepts beats only when high.
- clr_stats, in, 1, single-cycle pulse; clears counters and capture, and drops lock.
- locked, out, 1, the expected counter is seeded.
- beat_cnt, out, 32, accepted beats, wrapping.
- pkt_cnt, out, 32, accepted tlast beats, wrapping.
- data_err_cnt, out, ERR_W, pattern, sequence and tkeep errors, saturating.
- last_err_cnt, out, ERR_W, tlast placement errors, saturating.
- first_err_valid, out, 1, sticky; first_err_data holds a capture.
- first_err_data, out, 64, tdata of the first erroneous beat since reset or clear.

Behaviour:
- Handshake:
  - s_axis_tready is a register equal to enable delayed by one cycle. It resets to 0 and is forced to 0 in the cycle after clr_stats.
  - A beat is accepted when tvalid && tready. Only accepted beats update any state.
- Field checks, applied to every accepted beat:
  - v = tdata[31:1].
  - fmt_ok = (tdata[0]==0) && (tdata[32]==1) && (tdata[63:33]==v).
  - keep_ok = (tkeep==all ones).
- State machine, two states:
  - UNLOCKED (reset state):
    - Accepted beat with fmt_ok && keep_ok: exp <= v+1 (31-bit, wraps 7FFFFFFF->0), go to LOCKED. tlast is not checked.
    - Any other accepted beat: data_err_cnt +1, stay in UNLOCKED.
  - LOCKED:
    - Good beat = fmt_ok && keep_ok && v==exp. On a good beat: exp <= exp+1.
    - fmt_ok but v!=exp, or !keep_ok: data_err_cnt +1, then resync with exp <= v+1 and stay in LOCKED.
    - !fmt_ok: data_err_cnt +1, go to UNLOCKED.
    - When fmt_ok, tlast must equal (v[PKT_LOG2-1:0]==all ones). A mismatch adds +1 to last_err_cnt and is independent of the data error. A beat can increment both counters.
- Counters:
  - beat_cnt +1 per accepted beat.
  - pkt_cnt +1 per accepted beat with tlast=1, in either state.
  - Error counters saturate at all ones.
- First-error capture: the first beat that increments either error counter latches tdata into first_err_data and sets first_err_valid. Later errors leave both unchanged until clear.
- Latency: every output updates on the clock edge that follows the accepting handshake, so values are visible one cycle after the beat.
- clr_stats (synchronous):
  - Zeroes all counters, first_err_valid and first_err_data, and sets state to UNLOCKED.
  - If a beat is accepted in the same cycle, clr wins and the beat is neither counted nor checked.
- Reset: user_resetn low asynchronously forces every output and internal register to 0 and state to UNLOCKED. Reset asserted mid-packet discards partial-packet state. After reset the checker re-locks on the first well-formed beat.
- enable low mid-packet stalls the stream without penalty; the sequence continues when enable returns.

Decomposition:
- Shared package xdma_pckt_pkg:
  - State enum.
  - PAT_ODD_BIT=1 and PAT_EVEN_BIT=0 marker constants.
  - Function pat_word(cnt) returning the expected 64-bit word, for use by both the checker and the bench.
- One natural sub-module: xdma_sat_cnt, a parameterised saturating counter with synchronous clear, instantiated twice.

Test Plan:
- Reset, enable=1, drive 1024 beats with cnt 0..1023 and tlast at 511 and 1023. Expect locked=1 after the first beat, beat_cnt=1024, pkt_cnt=2, both error counters 0, first_err_valid=0.
- Locked at exp=100, inject cnt=105 (well-formed). Expect data_err_cnt=1, first_err_data=pat_word(105), then cnt=106 accepted with no further error.
- Corrupt tdata[32]=0 on the beat with cnt=10. Expect data_err_cnt=1 and locked=0 one cycle later, then re-lock on cnt=11 with no further errors.
- tlast asserted on cnt=300 and missing on cnt=511. Expect last_err_cnt=2, data_err_cnt=0, pkt_cnt counts only the cnt=300 beat.
- Seed cnt=7FFFFFFE and send 4 beats wrapping through 0. Expect 0 errors. Then pulse clr_stats coincident with a valid beat: all counters 0, locked=0, s_axis_tready=0 for one cycle, that beat not counted.
- Random tready stalls via enable toggling, plus 70000 injected errors. Expect data_err_cnt to saturate at 16'hFFFF with no wrap. Assert user_resetn mid-packet: all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/xdma_pckt_pkg.sv
// Shared definitions for the XDMA H2C counter-pattern checker and its bench.
package xdma_pckt_pkg;

  typedef enum logic [0:0] {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } chk_state_e;

  localparam logic PAT_ODD_BIT  = 1'b1;
  localparam logic PAT_EVEN_BIT = 1'b0;

  // Word the C2H generator emits for a given 31-bit count.
  function automatic logic [63:0] pat_word(input logic [30:0] cnt);
    return {cnt, PAT_ODD_BIT, cnt, PAT_EVEN_BIT};
  endfunction

endpackage

// File: rtl/xdma_sat_cnt.sv
// Up-counter that sticks at all ones, with synchronous clear.
module xdma_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !(&r_cnt)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/xdma_pckt_chk.sv
// H2C stream sink that checks every accepted beat against the C2H counter pattern.
//   state       | meaning
//   ST_UNLOCKED | no expected count yet; next well-formed beat seeds it
//   ST_LOCKED   | r_exp holds the count the next beat must carry
module xdma_pckt_chk
  import xdma_pckt_pkg::*;
#(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8,
  parameter int PKT_LOG2     = 9,
  parameter int ERR_W        = 16,
  parameter int TCQ          = 1
) (
  input  logic                    user_clk,
  input  logic                    user_resetn,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [C_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic                    s_axis_tlast,
  input  logic                    enable,
  input  logic                    clr_stats,
  output logic                    locked,
  output logic [31:0]             beat_cnt,
  output logic [31:0]             pkt_cnt,
  output logic [ERR_W-1:0]        data_err_cnt,
  output logic [ERR_W-1:0]        last_err_cnt,
  output logic                    first_err_valid,
  output logic [63:0]             first_err_data
);

  // Only the 64-bit datapath exists; reject other builds at elaboration.
  if (C_DATA_WIDTH != 64 || KEEP_WIDTH != C_DATA_WIDTH / 8 || TCQ < 0) begin : g_param_err
    $error("xdma_pckt_chk: unsupported parameter set");
  end

  chk_state_e    r_state;
  logic [30:0]   r_exp;
  logic          r_tready;
  logic [31:0]   r_beat_cnt;
  logic [31:0]   r_pkt_cnt;
  logic          r_fev;
  logic [63:0]   r_fed;

  logic [30:0]   w_v;
  logic          w_fmt_ok;
  logic          w_keep_ok;
  logic          w_acc;
  logic          w_locked_st;
  logic          w_tlast_exp;
  logic          w_data_err;
  logic          w_last_err;

  assign w_v         = s_axis_tdata[31:1];
  assign w_fmt_ok    = (s_axis_tdata[0] == PAT_EVEN_BIT) && (s_axis_tdata[32] == PAT_ODD_BIT) &&
                       (s_axis_tdata[63:33] == w_v);
  assign w_keep_ok   = &s_axis_tkeep;
  assign w_acc       = s_axis_tvalid && r_tready;
  assign w_locked_st = (r_state == ST_LOCKED);
  assign w_tlast_exp = &w_v[PKT_LOG2-1:0];

  assign w_data_err = w_acc && (w_locked_st ? !(w_fmt_ok && w_keep_ok && (w_v == r_exp))
                                            : !(w_fmt_ok && w_keep_ok));
  assign w_last_err = w_acc && w_locked_st && w_fmt_ok && (s_axis_tlast != w_tlast_exp);

  always_ff @(posedge user_clk or negedge user_resetn) begin
    if (!user_resetn) begin
      r_tready <= 1'b0;
    end else begin
      r_tready <= enable && !clr_stats;
    end
  end

  // A well-formed beat always resyncs r_exp; in UNLOCKED it also needs full tkeep.
  always_ff @(posedge user_clk or negedge user_resetn) begin
    if (!user_resetn) begin
      r_state <= ST_UNLOCKED;
      r_exp   <= '0;
    end else if (clr_stats) begin
      r_state <= ST_UNLOCKED;
      r_exp   <= '0;
    end else if (w_acc) begin
      if (w_fmt_ok && (w_locked_st || w_keep_ok)) begin
        r_exp   <= w_v + 31'd1;
        r_state <= ST_LOCKED;
      end else if (!w_fmt_ok) begin
        r_state <= ST_UNLOCKED;
      end
    end
  end

  always_ff @(posedge user_clk or negedge user_resetn) begin
    if (!user_resetn) begin
      r_beat_cnt <= '0;
      r_pkt_cnt  <= '0;
      r_fev      <= 1'b0;
      r_fed      <= '0;
    end else if (clr_stats) begin
      r_beat_cnt <= '0;
      r_pkt_cnt  <= '0;
      r_fev      <= 1'b0;
      r_fed      <= '0;
    end else begin
      if (w_acc) begin
        r_beat_cnt <= r_beat_cnt + 32'd1;
      end
      if (w_acc && s_axis_tlast) begin
        r_pkt_cnt <= r_pkt_cnt + 32'd1;
      end
      if (!r_fev && (w_data_err || w_last_err)) begin
        r_fev <= 1'b1;
        r_fed <= s_axis_tdata;
      end
    end
  end

  xdma_sat_cnt #(.W(ERR_W)) u_data_err_cnt (
    .clk   (user_clk),
    .rst_n (user_resetn),
    .i_clr (clr_stats),
    .i_inc (w_data_err),
    .o_cnt (data_err_cnt)
  );

  xdma_sat_cnt #(.W(ERR_W)) u_last_err_cnt (
    .clk   (user_clk),
    .rst_n (user_resetn),
    .i_clr (clr_stats),
    .i_inc (w_last_err),
    .o_cnt (last_err_cnt)
  );

  assign s_axis_tready   = r_tready;
  assign locked          = w_locked_st;
  assign beat_cnt        = r_beat_cnt;
  assign pkt_cnt         = r_pkt_cnt;
  assign first_err_valid = r_fev;
  assign first_err_data  = r_fed;

endmodule
